ps2_key_tracker: RTL

Parametrised PS/2 set-2 scancode tracker between `PS2_Controller` (byte stream) and game/control logic. Parses the E0 (extended) and F0 (break) prefixes into complete make/break events and matches them against a table of `NUM_KEYS` key codes. Keeps a held-level per key and emits one-cycle press/release pulses, so typematic repeats never retrigger. Replaces single-key last-byte latching with true multi-key, simultaneous-hold tracking.

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_key_tracker_seq_parser.sv | 73 +++++++
 rtl/ps2_key_tracker.sv | 76 +++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants, parser state and event payload for the key tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int unsigned PS2_NUM_DROP = 7;
  localparam logic [7:0] PS2_DROP [PS2_NUM_DROP] =
    '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};

  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_DOWN  = 9'h172;
  localparam logic [8:0] KEY_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_RIGHT = 9'h174;

  // Entry 0 sits in the low bits, so index 0 = up, 3 = right.
  localparam logic [35:0] KEY_ARROWS = {KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_t;

  typedef struct packed {
    logic       valid;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  function automatic logic is_dropped(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_DROP; i++) begin
      if (b == PS2_DROP[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_tracker_seq_parser.sv
// Prefix parser: folds E0/F0 prefixes into make/break events, abandons stale prefixes on timeout.
module ps2_seq_parser
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output ps2_evt_t   evt_c
);

  ps2_state_t           state;
  logic [TIMEOUT_W-1:0] tmo_cnt;

  // Event decode is combinational so the tracker registers it at t+1.
  always_comb begin
    evt_c      = '0;
    evt_c.code = rx_data;
    if (rx_valid) begin
      unique case (state)
        ST_IDLE: evt_c.valid = (rx_data != PS2_EXT) && (rx_data != PS2_BRK) && !is_dropped(rx_data);
        ST_EXT: begin
          evt_c.valid = (rx_data != PS2_EXT) && (rx_data != PS2_BRK);
          evt_c.ext   = 1'b1;
        end
        ST_BRK: begin
          evt_c.valid = (rx_data != PS2_EXT) && (rx_data != PS2_BRK);
          evt_c.brk   = 1'b1;
        end
        ST_EXT_BRK: begin
          evt_c.valid = (rx_data != PS2_EXT) && (rx_data != PS2_BRK);
          evt_c.ext   = 1'b1;
          evt_c.brk   = 1'b1;
        end
        default: evt_c.valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else if (rx_valid) begin
      tmo_cnt <= '0;
      unique case (state)
        ST_IDLE: begin
          if (rx_data == PS2_EXT)      state <= ST_EXT;
          else if (rx_data == PS2_BRK) state <= ST_BRK;
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK)      state <= ST_EXT_BRK;
          else if (rx_data != PS2_EXT) state <= ST_IDLE;
        end
        ST_BRK: begin
          if (rx_data == PS2_EXT)      state <= ST_EXT_BRK;
          else if (rx_data != PS2_BRK) state <= ST_IDLE;
        end
        ST_EXT_BRK: begin
          if ((rx_data != PS2_EXT) && (rx_data != PS2_BRK)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      // Saturating counter; reaching all-ones drops the partial prefix.
      if (tmo_cnt == '1) state   <= ST_IDLE;
      else               tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Multi-key PS/2 held/press/release tracker over a configurable code table.
// Optional PS2_KEY_TOGGLE_EN adds per-key toggle registers flipped on each press.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned               NUM_KEYS  = 4,
  parameter logic [9*NUM_KEYS-1:0]     KEY_CODES = (9*NUM_KEYS)'(KEY_ARROWS),
  parameter int unsigned               TIMEOUT_W = 20
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle,
  output logic                any_held,
  output logic [8:0]          last_code,
  output logic                last_break,
  output logic                event_valid
);

  ps2_evt_t            evt_c;
  logic [NUM_KEYS-1:0] match_c;
  logic [NUM_KEYS-1:0] fresh_c;
  logic [NUM_KEYS-1:0] rel_c;

  ps2_seq_parser #(.TIMEOUT_W(TIMEOUT_W)) u_parser (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .evt_c    (evt_c)
  );

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_match
    assign match_c[i] = (KEY_CODES[9*i +: 9] == {evt_c.ext, evt_c.code});
  end

  // Typematic repeats of a held key and breaks of an idle key fall out here.
  assign fresh_c = match_c & ~key_held & {NUM_KEYS{evt_c.valid & ~evt_c.brk}};
  assign rel_c   = match_c &  key_held & {NUM_KEYS{evt_c.valid &  evt_c.brk}};

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
      last_code   <= 9'h000;
      last_break  <= 1'b0;
      event_valid <= 1'b0;
    end else begin
      key_held    <= (key_held | fresh_c) & ~rel_c;
      key_press   <= fresh_c;
      key_release <= rel_c;
      event_valid <= evt_c.valid;
      if (evt_c.valid) begin
        last_code  <= {evt_c.ext, evt_c.code};
        last_break <= evt_c.brk;
      end
    end
  end

  assign any_held = |key_held;

`ifdef PS2_KEY_TOGGLE_EN
  always_ff @(posedge CLOCK_50) begin
    if (!reset) key_toggle <= '0;
    else        key_toggle <= key_toggle ^ fresh_c;
  end
`else
  assign key_toggle = '0;
`endif

endmodule
